// File: rtl/burst_ram_pkg.sv
// Shared definitions for the BurstRAM command interface.
// The command encodings are also used by the cache arbiter.
package burst_ram_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [4:0] {
        S_INIT       = 5'b00001,
        S_IDLE       = 5'b00010,
        S_READ_WAIT  = 5'b00100,
        S_READ_DATA  = 5'b01000,
        S_WRITE_DATA = 5'b10000
    } state_t;

endpackage

// File: rtl/burst_ram_array.sv
// Single-port synchronous RAM with byte-write enables and registered read.
// Contents have no reset so it maps onto FPGA block RAM.
module burst_ram_array #(
    parameter int ADDR_BITWIDTH = 4,
    parameter int DATA_BITWIDTH = 64
) (
    input  logic                       clk,
    input  logic                       re,
    input  logic [DATA_BITWIDTH/8-1:0] be,
    input  logic [ADDR_BITWIDTH-1:0]   addr,
    input  logic [DATA_BITWIDTH-1:0]   wdata,
    output logic [DATA_BITWIDTH-1:0]   q
);

    logic [DATA_BITWIDTH-1:0] mem [2**ADDR_BITWIDTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DATA_BITWIDTH / 8; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/burst_ram.sv
// BurstRAM responder: accepts read/write burst commands, returns read bursts
// after a fixed latency, and holds br_busy during commands and post-reset init.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH           = 4,
    parameter int DATA_BITWIDTH            = 64,
    parameter int BURST_DATA_COUNT         = 4,
    parameter int CYCLES_BEFORE_DATA_VALID = 4,
    parameter int INIT_CYCLES              = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       br_cmd,
    input  logic                       br_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]  br_addr,
    input  logic [DATA_BITWIDTH-1:0]   br_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0] br_data_mask,
    output logic [DATA_BITWIDTH-1:0]   br_rd_data,
    output logic                       br_rd_data_valid,
    output logic                       br_busy
);

    localparam int CNT_MAX = (INIT_CYCLES > CYCLES_BEFORE_DATA_VALID) ?
                             INIT_CYCLES : CYCLES_BEFORE_DATA_VALID;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BEAT_W  = $clog2(BURST_DATA_COUNT + 1);

    state_t                     state;
    logic [DEPTH_BITWIDTH-1:0]  addr_r;
    logic [BEAT_W-1:0]          beat;
    logic [CNT_W-1:0]           cnt;
    logic                       rd_pend;

    logic                       accept;
    logic                       rd_issue;
    logic                       wr_en;
    logic [DEPTH_BITWIDTH-1:0]  ram_addr;
    logic [DATA_BITWIDTH/8-1:0] ram_be;
    logic [DATA_BITWIDTH-1:0]   ram_q;

    // The array read is issued one edge ahead of each beat; rd_pend marks that
    // ram_q holds a fresh beat to be registered onto br_rd_data.
    always_comb begin
        accept   = (state == S_IDLE) && !br_busy && br_cmd_en;
        rd_issue = (accept && br_cmd == CMD_READ && CYCLES_BEFORE_DATA_VALID == 1)
                || (state == S_READ_WAIT && cnt == CNT_W'(CYCLES_BEFORE_DATA_VALID - 2))
                || (state == S_READ_DATA && beat < BEAT_W'(BURST_DATA_COUNT));
        wr_en    = (accept && br_cmd == CMD_WRITE) || (state == S_WRITE_DATA);
        ram_addr = accept ? br_addr : addr_r + DEPTH_BITWIDTH'(beat);
        ram_be   = wr_en ? ~br_data_mask : '0;
    end

    burst_ram_array #(
        .ADDR_BITWIDTH (DEPTH_BITWIDTH),
        .DATA_BITWIDTH (DATA_BITWIDTH)
    ) u_array (
        .clk   (clk),
        .re    (rd_issue),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (br_wr_data),
        .q     (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_INIT;
            br_busy          <= 1'b1;
            br_rd_data_valid <= 1'b0;
            br_rd_data       <= '0;
            addr_r           <= '0;
            beat             <= '0;
            cnt              <= '0;
            rd_pend          <= 1'b0;
        end else begin
            rd_pend          <= rd_issue;
            br_rd_data_valid <= rd_pend;
            if (rd_pend) begin
                br_rd_data <= ram_q;
            end
            unique case (state)
                S_INIT: begin
                    if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        state   <= S_IDLE;
                        br_busy <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        addr_r <= br_addr;
                        cnt    <= '0;
                        if (br_cmd == CMD_READ) begin
                            br_busy <= 1'b1;
                            if (CYCLES_BEFORE_DATA_VALID == 1) begin
                                state <= S_READ_DATA;
                                beat  <= BEAT_W'(1);
                            end else begin
                                state <= S_READ_WAIT;
                                beat  <= '0;
                            end
                        end else begin
                            beat <= BEAT_W'(1);
                            if (BURST_DATA_COUNT > 1) begin
                                state   <= S_WRITE_DATA;
                                br_busy <= 1'b1;
                            end
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (cnt == CNT_W'(CYCLES_BEFORE_DATA_VALID - 2)) begin
                        state <= S_READ_DATA;
                        beat  <= BEAT_W'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_READ_DATA: begin
                    // Leave only once the last issued beat has been presented.
                    if (beat < BEAT_W'(BURST_DATA_COUNT)) begin
                        beat <= beat + 1'b1;
                    end else if (!rd_pend) begin
                        state   <= S_IDLE;
                        br_busy <= 1'b0;
                    end
                end
                S_WRITE_DATA: begin
                    if (beat == BEAT_W'(BURST_DATA_COUNT - 1)) begin
                        state   <= S_IDLE;
                        br_busy <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state   <= S_INIT;
                    br_busy <= 1'b1;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram.sv
// Scoreboard bench for burst_ram: stimulus pushes expected read beats with
// their due cycle; a negedge monitor pops and compares every valid beat.
module tb_burst_ram;

    localparam int L = 4;
    localparam int N = 4;

    typedef logic [63:0] burst_t [N];
    typedef logic [7:0]  mask_t  [N];
    typedef struct {
        logic [63:0] data;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_cmd = 1'b0;
    logic        br_cmd_en = 1'b0;
    logic [3:0]  br_addr = '0;
    logic [63:0] br_wr_data = '0;
    logic [7:0]  br_data_mask = '1;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    exp_t        sb[$];

    burst_ram #(
        .DEPTH_BITWIDTH           (4),
        .DATA_BITWIDTH            (64),
        .BURST_DATA_COUNT         (N),
        .CYCLES_BEFORE_DATA_VALID (L),
        .INIT_CYCLES              (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (br_rd_data_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", br_rd_data_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat_data", br_rd_data, e.data);
                chk("beat_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (br_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", br_busy, 1'b0);
    endtask

    task automatic check_init();
        int n = 0;
        while (br_busy && n < 50) begin
            chk("init_valid_low", br_rd_data_valid, 1'b0);
            n++;
            @(negedge clk);
        end
        chk("init_busy_cycles", 64'(n), 64'd8);
    endtask

    task automatic write_burst(input logic [3:0] a, input burst_t d, input mask_t m);
        wait_idle();
        br_cmd_en = 1'b1; br_cmd = 1'b1; br_addr = a;
        br_wr_data = d[0]; br_data_mask = m[0];
        @(negedge clk);
        br_cmd_en = 1'b0;
        chk("wr_busy_high", br_busy, 1'b1);
        for (int k = 1; k < N; k++) begin
            br_wr_data = d[k]; br_data_mask = m[k];
            @(negedge clk);
        end
        chk("wr_busy_low", br_busy, 1'b0);
        br_data_mask = '1;
    endtask

    task automatic read_burst(input logic [3:0] a, input burst_t d, input bit inject);
        int unsigned t;
        wait_idle();
        br_cmd_en = 1'b1; br_cmd = 1'b0; br_addr = a;
        t = cyc + 1;
        for (int k = 0; k < N; k++) sb.push_back('{d[k], t + L + k});
        @(negedge clk);
        br_cmd_en = 1'b0;
        chk("rd_busy_high", br_busy, 1'b1);
        if (inject) begin
            // stray read during READ_WAIT, stray write during READ_DATA
            @(negedge clk);
            br_cmd_en = 1'b1; br_cmd = 1'b0; br_addr = 4'd8;
            @(negedge clk);
            br_cmd_en = 1'b0;
            repeat (2) @(negedge clk);
            br_cmd_en = 1'b1; br_cmd = 1'b1; br_addr = 4'd4;
            br_wr_data = 64'hDEAD_BEEF_DEAD_BEEF; br_data_mask = '0;
            @(negedge clk);
            br_cmd_en = 1'b0; br_data_mask = '1;
        end
        wait_idle();
        chk("rd_busy_drop_cycle", 64'(cyc), 64'(t + L + N));
        chk("rd_valid_at_drop", br_rd_data_valid, 1'b0);
        chk("rd_drained", 64'(sb.size()), 64'd0);
    endtask

    localparam logic [63:0] V11 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] V22 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] V33 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] V44 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] VA0 = 64'hA0A0_A0A0_A0A0_A0A0;
    localparam logic [63:0] VA1 = 64'hA1A1_A1A1_A1A1_A1A1;
    localparam logic [63:0] VA2 = 64'hA2A2_A2A2_A2A2_A2A2;
    localparam logic [63:0] VA3 = 64'hA3A3_A3A3_A3A3_A3A3;
    localparam logic [63:0] VFF = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int unsigned t;
        repeat (2) @(negedge clk);
        chk("rst_busy", br_busy, 1'b1);
        chk("rst_valid", br_rd_data_valid, 1'b0);
        chk("rst_rd_data", br_rd_data, 64'd0);
        rst = 1'b0;
        check_init();

        write_burst(4'd2, '{V11, V22, V33, V44}, '{8'h00, 8'h00, 8'h00, 8'h00});
        read_burst(4'd2, '{V11, V22, V33, V44}, 1'b0);

        write_burst(4'd8, '{VFF, VFF, VFF, VFF}, '{8'h00, 8'h00, 8'h00, 8'h00});
        write_burst(4'd8, '{64'd0, 64'd0, 64'd0, 64'd0}, '{8'h0F, 8'hFF, 8'hFF, 8'hFF});
        read_burst(4'd8, '{64'h0000_0000_FFFF_FFFF, VFF, VFF, VFF}, 1'b0);

        write_burst(4'd14, '{VA0, VA1, VA2, VA3}, '{8'h00, 8'h00, 8'h00, 8'h00});
        read_burst(4'd14, '{VA0, VA1, VA2, VA3}, 1'b0);
        read_burst(4'd0, '{VA2, VA3, V11, V22}, 1'b0);
        read_burst(4'd1, '{VA3, V11, V22, V33}, 1'b0);

        read_burst(4'd2, '{V11, V22, V33, V44}, 1'b1);
        read_burst(4'd2, '{V11, V22, V33, V44}, 1'b0);

        // reset lands while beat 2 of a read is on the bus
        wait_idle();
        br_cmd_en = 1'b1; br_cmd = 1'b0; br_addr = 4'd8;
        t = cyc + 1;
        for (int k = 0; k < N; k++) sb.push_back('{(k == 0) ? 64'h0000_0000_FFFF_FFFF : VFF, t + L + k});
        @(negedge clk);
        br_cmd_en = 1'b0;
        while (cyc < t + L + 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", br_rd_data_valid, 1'b0);
        chk("midrst_busy", br_busy, 1'b1);
        chk("midrst_rd_data", br_rd_data, 64'd0);
        chk("midrst_beats_left", 64'(sb.size()), 64'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check_init();
        read_burst(4'd14, '{VA0, VA1, VA2, VA3}, 1'b0);

        repeat (8) @(negedge clk);
        chk("final_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
